// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the processor datapath.
// Contents:
//   DMEM_DATA_W / DMEM_ADDR_W : default word and address widths
//   dmem_state_e              : responder FSM encoding (2'd3 is unreachable and
//                               falls back to IDLE)
//   dmem_cnt_width()          : wait-counter width for a given wait-state count
package dmem_pkg;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // $clog2(1) is 0, so zero wait states still get a one-bit counter.
  function automatic int dmem_cnt_width(input int waits);
    return (waits > 0) ? $clog2(waits + 1) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data-memory responder.
// Ports:
//   clk   in  clock; write and read both take effect on the rising edge
//   we    in  write enable
//   addr  in  word address (shared by write and read)
//   wdata in  write data
//   rdata out registered read data (old contents on a same-cycle write)
// The storage has no reset; contents survive a responder reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the processor data-memory interface. Accepts one load or
// store at a time, inserts WAIT_CYCLES wait states, performs the access and
// presents a back-pressure-safe response.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous active-high reset of all control state
//   req_valid in   request present
//   req_write in   1 = store, 0 = load
//   req_addr  in   word address
//   req_wdata in   store data
//   req_ready out  request can be accepted (IDLE)
//   rsp_valid out  response present (RESP)
//   rsp_rdata out  load data, or the stored word for a store
//   rsp_write out  response belongs to a store
//   rsp_ready in   requester takes the response
//   busy      out  a request is in flight
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam int              CNT_W    = dmem_cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;

  logic              rsp_write_q;
  logic              rsp_sel_mem_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic              accept;
  logic              access;
  logic              rsp_done;
  logic              mem_we;
  logic [DATA_W-1:0] arr_rdata;

  assign accept   = (state_q == IDLE) && req_valid;
  assign access   = (state_q == BUSY) && (cnt_q == '0);
  assign rsp_done = (state_q == RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state; the store strobe is combinational so that a
  // reset during BUSY removes it before the commit edge.
  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == RESP);
    mem_we    = access && write_q;
  end

  // Request fields are captured only at the accepting edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      write_q <= req_write;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Load data comes straight from the array's read register while in RESP
  // (address is held and no write happens there, so it is stable). When the
  // response is taken the value is copied into rsp_rdata_q so the output
  // keeps the last response afterwards, and reset can force it to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_write_q   <= 1'b0;
      rsp_sel_mem_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else if (access) begin
      rsp_write_q   <= write_q;
      rsp_sel_mem_q <= !write_q;
      if (write_q) begin
        rsp_rdata_q <= wdata_q;
      end
    end else if (rsp_done) begin
      if (rsp_sel_mem_q) begin
        rsp_rdata_q <= arr_rdata;
      end
      rsp_sel_mem_q <= 1'b0;
    end
  end

  assign rsp_rdata = rsp_sel_mem_q ? arr_rdata : rsp_rdata_q;
  assign rsp_write = rsp_write_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req_valid, req_write, rsp_ready;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;

  int sel  = 0;
  int wexp = 2;
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: WAIT_CYCLES = 2, instance B: WAIT_CYCLES = 0.
  logic        req_ready_a, rsp_valid_a, rsp_write_a, busy_a;
  logic [15:0] rsp_rdata_a;
  logic        req_ready_b, rsp_valid_b, rsp_write_b, busy_b;
  logic [15:0] rsp_rdata_b;
  logic        req_valid_a, req_valid_b, rsp_ready_a, rsp_ready_b;

  assign req_valid_a = req_valid && (sel == 0);
  assign req_valid_b = req_valid && (sel == 1);
  assign rsp_ready_a = rsp_ready && (sel == 0);
  assign rsp_ready_b = rsp_ready && (sel == 1);

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_write(rsp_write_a),
    .rsp_ready(rsp_ready_a), .busy(busy_a)
  );

  data_mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_write(rsp_write_b),
    .rsp_ready(rsp_ready_b), .busy(busy_b)
  );

  logic        o_req_ready, o_rsp_valid, o_rsp_write, o_busy;
  logic [15:0] o_rsp_rdata;
  assign o_req_ready = (sel == 0) ? req_ready_a : req_ready_b;
  assign o_rsp_valid = (sel == 0) ? rsp_valid_a : rsp_valid_b;
  assign o_rsp_write = (sel == 0) ? rsp_write_a : rsp_write_b;
  assign o_busy      = (sel == 0) ? busy_a      : busy_b;
  assign o_rsp_rdata = (sel == 0) ? rsp_rdata_a : rsp_rdata_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (dut %0d, cycle %0d)", tag, obs, exp, sel, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] a, input logic [15:0] d);
    int t;
    t = 0;
    while (!o_req_ready && t < 50) begin
      step();
      t++;
    end
    chk("req_ready_before_issue", {31'd0, o_req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    step();
    acc_cyc   = cyc;
    req_valid = 1'b0;
    // Scramble the request bus: only the accepting edge may be used.
    req_write = ~wr;
    req_addr  = ~a;
    req_wdata = ~d;
    chk("busy_after_accept", {31'd0, o_busy}, 32'd1);
    chk("req_ready_after_accept", {31'd0, o_req_ready}, 32'd0);
  endtask

  task automatic wait_rsp(input logic wr, input logic [15:0] exp);
    int lat;
    lat = 0;
    while (!o_rsp_valid && lat < 50) begin
      step();
      lat++;
    end
    chk("latency", lat, wexp + 1);
    chk("rsp_write", {31'd0, o_rsp_write}, {31'd0, wr});
    chk("rsp_rdata", {16'd0, o_rsp_rdata}, {16'd0, exp});
  endtask

  task automatic accept_rsp(input int gap, input logic [15:0] exp);
    repeat (gap) begin
      step();
      chk("rsp_valid_held", {31'd0, o_rsp_valid}, 32'd1);
      chk("rsp_rdata_held", {16'd0, o_rsp_rdata}, {16'd0, exp});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_dropped", {31'd0, o_rsp_valid}, 32'd0);
    chk("req_ready_after_rsp", {31'd0, o_req_ready}, 32'd1);
  endtask

  task automatic txn(input logic wr, input logic [7:0] a, input logic [15:0] d,
                     input logic [15:0] exp, input int gap);
    issue(wr, a, d);
    wait_rsp(wr, exp);
    accept_rsp(gap, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "timeout");
  end

  logic [15:0] refm [2][8];

  initial begin
    logic        wr;
    logic [15:0] d, e;
    int          idx, gap;

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b0;
    req_addr = 8'h00; req_wdata = 16'h0000;

    // Reset asserted between clock edges
    #2 reset = 1'b1;
    #1;
    chk("reset_req_ready_a", {31'd0, req_ready_a}, 32'd1);
    chk("reset_rsp_valid_a", {31'd0, rsp_valid_a}, 32'd0);
    chk("reset_rsp_rdata_a", {16'd0, rsp_rdata_a}, 32'h0);
    chk("reset_rsp_write_a", {31'd0, rsp_write_a}, 32'd0);
    chk("reset_busy_a",      {31'd0, busy_a},      32'd0);
    chk("reset_req_ready_b", {31'd0, req_ready_b}, 32'd1);
    chk("reset_rsp_valid_b", {31'd0, rsp_valid_b}, 32'd0);
    chk("reset_busy_b",      {31'd0, busy_b},      32'd0);
    step(); step();
    reset = 1'b0;
    step();

    // Store then load, two wait states
    sel = 0; wexp = 2;
    txn(1'b1, 8'h10, 16'hBEEF, 16'hBEEF, 0);
    txn(1'b0, 8'h10, 16'h0000, 16'hBEEF, 0);

    // Back-pressure with a competing request held on the bus
    issue(1'b1, 8'h11, 16'hC0DE);
    wait_rsp(1'b1, 16'hC0DE);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h11; req_wdata = 16'hDEAD;
    repeat (10) begin
      step();
      chk("bp_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
      chk("bp_rsp_rdata", {16'd0, o_rsp_rdata}, 32'hC0DE);
      chk("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    step();
    rsp_ready = 1'b0;
    chk("bp_rsp_dropped", {31'd0, o_rsp_valid}, 32'd0);
    chk("bp_rdata_kept", {16'd0, o_rsp_rdata}, 32'hC0DE);
    step();
    chk("bp_not_queued", {31'd0, o_busy}, 32'd0);
    txn(1'b0, 8'h11, 16'h0000, 16'hC0DE, 0);

    // Reset while a store is still waiting
    txn(1'b1, 8'h20, 16'h5555, 16'h5555, 0);
    issue(1'b1, 8'h20, 16'hAAAA);
    step();
    reset = 1'b1;
    #1;
    chk("rst_busy_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_busy_busy",      {31'd0, o_busy},      32'd0);
    chk("rst_busy_req_ready", {31'd0, o_req_ready}, 32'd1);
    step(); step();
    reset = 1'b0;
    step();
    txn(1'b0, 8'h20, 16'h0000, 16'h5555, 0);

    // Reset while a committed store waits in RESP
    issue(1'b1, 8'h21, 16'h7777);
    wait_rsp(1'b1, 16'h7777);
    reset = 1'b1;
    #1;
    chk("rst_resp_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_resp_rsp_rdata", {16'd0, o_rsp_rdata}, 32'h0);
    chk("rst_resp_rsp_write", {31'd0, o_rsp_write}, 32'd0);
    step();
    reset = 1'b0;
    step();
    txn(1'b0, 8'h21, 16'h0000, 16'h7777, 0);

    // Zero wait states, top address
    sel = 1; wexp = 0;
    step();
    txn(1'b1, 8'h00, 16'h0F0F, 16'h0F0F, 0);
    txn(1'b1, 8'hFF, 16'h1234, 16'h1234, 1);
    txn(1'b0, 8'hFF, 16'h0000, 16'h1234, 0);
    txn(1'b0, 8'h00, 16'h0000, 16'h0F0F, 0);

    // Random traffic against a reference array, both instances
    for (int s = 0; s < 2; s++) begin
      sel  = s;
      wexp = (s == 0) ? 2 : 0;
      step();
      for (int i = 0; i < 8; i++) begin
        d = 16'($urandom);
        refm[s][i] = d;
        txn(1'b1, 8'h40 + 8'(i), d, d, 0);
      end
      for (int k = 0; k < 16; k++) begin
        wr  = 1'($urandom_range(0, 1));
        idx = $urandom_range(0, 7);
        d   = 16'($urandom);
        gap = $urandom_range(0, 3);
        e   = wr ? d : refm[s][idx];
        issue(wr, 8'h40 + 8'(idx), d);
        if (k > 0) begin
          chk("spacing", {31'd0, (acc_cyc - last_acc) >= (wexp + 3)}, 32'd1);
        end
        last_acc = acc_cyc;
        wait_rsp(wr, e);
        accept_rsp(gap, e);
        if (wr) refm[s][idx] = d;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
